// File: rtl/bumpy_pkg.sv
// Shared definitions for the Bumpy play field: tile codes, map geometry
// and the tile-map sequencing states.
package bumpy_pkg;
  localparam logic [1:0] TILE_BG    = 2'b00;
  localparam logic [1:0] TILE_FLOOR = 2'b01;
  localparam logic [1:0] TILE_GIFT  = 2'b10;
  localparam logic [1:0] TILE_HOLE  = 2'b11;

  localparam int MAP_COLS_DEF   = 20;
  localparam int MAP_ROWS_DEF   = 15;
  localparam int TILE_SHIFT_DEF = 5;
  localparam int GIFT_W_DEF     = 6;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } map_state_t;
endpackage

// File: rtl/gift_tile_map_level_rom.sv
// Synchronous level ROM: one 2-bit tile code per map address, 1-cycle latency.
// LEVEL_ID 0 is the normal level; LEVEL_ID 1 is a gift-flooded level.
module level_rom
  import bumpy_pkg::*;
#(
  parameter int AW       = 9,
  parameter int LEVEL_ID = 0
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output logic [1:0]    o_data
);
  // Addresses assume a 20-column map: bottom row is floor, hole at (18,13).
  function automatic logic [1:0] rom_word(input int a);
    logic [1:0] code;
    code = TILE_BG;
    if (a >= 280 && a < 300) code = TILE_FLOOR;
    else if (a == 278) code = TILE_HOLE;
    else if (LEVEL_ID == 1) begin
      if (a < 70) code = TILE_GIFT;
    end
    else if (a == 22 || a == 110 || a == 197) code = TILE_GIFT;
    else if (a >= 65 && a <= 69) code = TILE_FLOOR;
    return code;
  endfunction

  logic [1:0] r_data;

  always_ff @(posedge i_clk) begin
    r_data <= rom_word(int'(i_addr));
  end

  assign o_data = r_data;
endmodule

// File: rtl/gift_tile_map.sv
// Tile-map store: copies the level ROM into a writable tile RAM, answers
// per-pixel tile lookups and turns collected gifts into background.
module gift_tile_map
  import bumpy_pkg::*;
#(
  parameter int MAP_COLS   = MAP_COLS_DEF,
  parameter int MAP_ROWS   = MAP_ROWS_DEF,
  parameter int TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int GIFT_W     = GIFT_W_DEF,
  parameter int LEVEL_ID   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic                  levelLoad,
  input  logic [10:0]           pixelX,
  input  logic [10:0]           pixelY,
  input  logic                  WriteEn,
  output logic                  drawing_request_Tile,
  output logic [1:0]            TileType,
  output logic [TILE_SHIFT-1:0] offsetX,
  output logic [TILE_SHIFT-1:0] offsetY,
  output logic [GIFT_W-1:0]     numOfGifts,
  output logic                  loadBusy
);
  localparam int N  = MAP_COLS * MAP_ROWS;
  localparam int AW = $clog2(N + 1);
  localparam logic [10:0]       COLS_L  = 11'(MAP_COLS);
  localparam logic [10:0]       ROWS_L  = 11'(MAP_ROWS);
  localparam logic [AW-1:0]     LAST_A  = AW'(N);
  localparam logic [GIFT_W-1:0] CNT_MAX = '1;

  map_state_t            r_state;
  logic [AW-1:0]         r_load_addr;
  logic [AW-1:0]         r_lk_addr;
  logic                  r_lk_in;
  logic [GIFT_W-1:0]     r_count;
  logic [1:0]            r_tile;
  logic                  r_draw;
  logic [TILE_SHIFT-1:0] r_off_x;
  logic [TILE_SHIFT-1:0] r_off_y;
  logic [1:0]            r_ram [N];

  logic [10:0]   w_col;
  logic [10:0]   w_row;
  logic          w_in_map;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_load_wa;
  logic [1:0]    w_rom_data;
  logic [1:0]    w_rd_code;
  logic [1:0]    w_look_code;
  logic [1:0]    w_disp;
  logic          w_run;
  logic          w_collect;
  logic          w_load_wr;

  level_rom #(.AW(AW), .LEVEL_ID(LEVEL_ID)) u_rom (
    .i_clk  (clk),
    .i_addr (r_load_addr),
    .o_data (w_rom_data)
  );

  assign w_col     = pixelX >> TILE_SHIFT;
  assign w_row     = pixelY >> TILE_SHIFT;
  assign w_in_map  = (w_col < COLS_L) && (w_row < ROWS_L);
  assign w_rd_addr = w_in_map ? AW'(w_row * COLS_L + w_col) : '0;
  assign w_rd_code = w_in_map ? r_ram[w_rd_addr] : TILE_BG;
  assign w_run     = (r_state == ST_RUN);

  // The strobe refers to the tile shown this cycle, i.e. last cycle's lookup.
  assign w_collect = w_run && WriteEn && !levelLoad && r_lk_in &&
                     (r_ram[r_lk_addr] == TILE_GIFT);
  assign w_look_code = (w_collect && w_in_map && (w_rd_addr == r_lk_addr)) ?
                       TILE_BG : w_rd_code;
  assign w_disp = ((w_look_code == TILE_HOLE) && (r_count != '0)) ? TILE_BG : w_look_code;

  // ROM data lags the address by one cycle, so address k writes word k-1.
  assign w_load_wr = (r_state == ST_LOAD) && !levelLoad && (r_load_addr != '0);
  assign w_load_wa = r_load_addr - AW'(1);

  always_ff @(posedge clk) begin
    if (w_load_wr) r_ram[w_load_wa] <= w_rom_data;
    else if (w_collect) r_ram[r_lk_addr] <= TILE_BG;
  end

  // LOAD: ROM->RAM copy plus drain, ARM: wait frame start, RUN: lookup+collect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_load_addr <= '0;
      r_count     <= '0;
      r_lk_addr   <= '0;
      r_lk_in     <= 1'b0;
      r_tile      <= TILE_BG;
      r_draw      <= 1'b0;
      r_off_x     <= '0;
      r_off_y     <= '0;
    end else begin
      r_lk_addr <= w_rd_addr;
      r_lk_in   <= w_in_map;
      r_tile    <= w_disp;
      r_draw    <= w_run && (w_disp != TILE_BG);
      r_off_x   <= pixelX[TILE_SHIFT-1:0];
      r_off_y   <= pixelY[TILE_SHIFT-1:0];
      if (levelLoad) begin
        r_state     <= ST_LOAD;
        r_load_addr <= '0;
        r_count     <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_load_wr && (w_rom_data == TILE_GIFT) && (r_count != CNT_MAX))
              r_count <= r_count + GIFT_W'(1);
            if (r_load_addr == LAST_A) r_state <= ST_ARM;
            else r_load_addr <= r_load_addr + AW'(1);
          end
          ST_ARM: begin
            if (startOfFrame) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_collect && (r_count != '0)) r_count <= r_count - GIFT_W'(1);
          end
          default: r_state <= ST_LOAD;
        endcase
      end
    end
  end

  assign TileType             = r_tile;
  assign drawing_request_Tile = r_draw;
  assign offsetX              = r_off_x;
  assign offsetY              = r_off_y;
  assign numOfGifts           = r_count;
  assign loadBusy             = (r_state != ST_RUN);
endmodule
